contador_param: RTL and testbench
=================================

CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits; legal range 2..16.
REQ-002 Parameter MAXVAL, default 2**WIDTH-1, terminal count; SHALL satisfy 1 <= MAXVAL <= 2**WIDTH-1.
REQ-003 CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 CLR  input  1  synchronous clear, active-high.
REQ-006 ENB  input  1  count/load enable, active-high.
REQ-007 MODE  input  2  operation: 00 hold, 01 up, 10 down, 11 load.
REQ-008 ONESHOT  input  1  1 = stop at terminal count; 0 = wrap.
REQ-009 D  input  WIDTH  load value.
REQ-010 Q  output  WIDTH  registered count.
REQ-011 RCO  output  1  registered ripple-carry pulse.
REQ-012 DONE  output  1  registered; high while in HALT state.
REQ-013 ERR  output  1  registered sticky out-of-range load flag.

Function
REQ-014 Two-state FSM: COUNT, HALT; DONE SHALL be 1 exactly when state is HALT.
REQ-015 Priority per edge: RESET (async) > CLR > ENB=0 > MODE.
REQ-016 CLR=1: Q<=0, RCO<=0, ERR<=0, state<=COUNT, regardless of ENB/MODE.
REQ-017 ENB=0 or MODE=00: Q, state, ERR held; RCO<=0.
REQ-018 COUNT, MODE=01: Q<MAXVAL -> Q<=Q+1; Q==MAXVAL -> terminal event.
REQ-019 COUNT, MODE=10: Q>0 -> Q<=Q-1; Q==0 -> terminal event.
REQ-020 Terminal event with ONESHOT=0: Q wraps (up: 0, down: MAXVAL), RCO<=1, state stays COUNT.
REQ-021 Terminal event with ONESHOT=1: Q unchanged (saturates), RCO<=1, state<=HALT.
REQ-022 ONESHOT SHALL be sampled only at a terminal event; changing it in HALT has no effect.
REQ-023 RCO SHALL be high for exactly one cycle after each terminal event and 0 otherwise.
REQ-024 HALT, MODE=01 or 10: Q held, RCO<=0, state stays HALT.
REQ-025 MODE=11 (either state): D<=MAXVAL -> Q<=D; D>MAXVAL -> Q<=MAXVAL and ERR<=1; state<=COUNT; RCO<=0.
REQ-026 ERR SHALL remain 1 until CLR or RESET; a later legal load SHALL NOT clear it.
REQ-027 Load into Q==MAXVAL (up) or Q==0 (down) SHALL NOT by itself generate RCO; the terminal event occurs on the next counting edge.
REQ-028 Arithmetic SHALL be modulo MAXVAL+1; Q SHALL never exceed MAXVAL.
REQ-029 Latency: every input effect visible on Q/RCO/DONE/ERR exactly one CLK edge later; no combinational input-to-output path.

Reset
REQ-030 RESET=0 SHALL immediately, without CLK, force Q=0, RCO=0, DONE=0, ERR=0, state=COUNT.
REQ-031 RESET asserted mid-count or in HALT SHALL abort the operation; no RCO pulse SHALL follow release.
REQ-032 After RESET release, first active edge SHALL obey REQ-015..REQ-025 normally.

Verification
REQ-033 Defaults, ENB=1, MODE=01, ONESHOT=0 from reset, 33 edges -> Q 1..31,0,1; RCO high only the cycle Q returns to 0.
REQ-034 MAXVAL=9, MODE=10, ONESHOT=0 from Q=0 -> Q=9 with RCO pulse, then 8,7,...; no value >9 ever.
REQ-035 Defaults, ONESHOT=1, MODE=01, load D=29 then count -> Q 29,30,31,31,31; RCO one pulse; DONE=1 from edge after Q reached 31; load D=5 -> DONE=0, Q=5.
REQ-036 MAXVAL=9, load D=12 -> Q=9, ERR=1; load D=3 -> Q=3, ERR stays 1; CLR -> Q=0, ERR=0.
REQ-037 ENB=0 with MODE=01 for 4 edges -> Q unchanged, RCO=0; CLR with ENB=1, MODE=11, D=7 simultaneously -> Q=0.
REQ-038 RESET pulsed low between edges at Q=17 -> Q=0 immediately, DONE=0; next edge with MODE=01 -> Q=1.

Source files
------------

// File: rtl/contador_param_if.sv
// ---------------------------------------------------------------------------
// contador_param_if: control/status bundle of the parameterised counter.
//   CLR      synchronous clear, active-high        (master -> slave)
//   ENB      count/load enable, active-high        (master -> slave)
//   MODE     00 hold, 01 up, 10 down, 11 load      (master -> slave)
//   ONESHOT  1 = stop at terminal count, 0 = wrap  (master -> slave)
//   D        load value, WIDTH bits                (master -> slave)
//   Q        registered count, WIDTH bits          (slave -> master)
//   RCO      registered ripple-carry pulse         (slave -> master)
//   DONE     registered, high while halted         (slave -> master)
//   ERR      registered sticky out-of-range load   (slave -> master)
// ---------------------------------------------------------------------------
interface contador_param_if #(
    parameter int unsigned WIDTH = 5
);
    logic             CLR;
    logic             ENB;
    logic [1:0]       MODE;
    logic             ONESHOT;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             DONE;
    logic             ERR;

    modport master (
        output CLR, ENB, MODE, ONESHOT, D,
        input  Q, RCO, DONE, ERR
    );

    modport slave (
        input  CLR, ENB, MODE, ONESHOT, D,
        output Q, RCO, DONE, ERR
    );
endinterface

// File: rtl/contador_param.sv
// ---------------------------------------------------------------------------
// contador_param: up/down/load counter with terminal count MAXVAL, either
// wrapping or one-shot (halting) at the terminal count.
//   CLK    rising-edge clock
//   RESET  asynchronous, active-low reset
//   bus    contador_param_if slave: CLR/ENB/MODE/ONESHOT/D in,
//          Q/RCO/DONE/ERR out (all outputs registered)
// ---------------------------------------------------------------------------
module contador_param #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned MAXVAL = 2**WIDTH - 1
) (
    input logic            CLK,
    input logic            RESET,
    contador_param_if.slave bus
);

    typedef enum logic [0:0] {StCount, StHalt} state_e;

    localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MAXVAL);
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StCount;
            q_q     <= '0;
            rco_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rco_q   <= rco_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rco_d   = 1'b0;
        err_d   = err_q;

        if (bus.CLR) begin
            state_d = StCount;
            q_d     = '0;
            err_d   = 1'b0;
        end else if (bus.ENB) begin
            unique case (bus.MODE)
                2'b00: begin
                end
                2'b01: begin
                    if (state_q == StCount) begin
                        if (q_q == MaxQ) begin
                            // Terminal event: ONESHOT only matters here.
                            rco_d = 1'b1;
                            if (bus.ONESHOT) state_d = StHalt;
                            else             q_d     = '0;
                        end else begin
                            q_d = q_q + One;
                        end
                    end
                end
                2'b10: begin
                    if (state_q == StCount) begin
                        if (q_q == '0) begin
                            rco_d = 1'b1;
                            if (bus.ONESHOT) state_d = StHalt;
                            else             q_d     = MaxQ;
                        end else begin
                            q_d = q_q - One;
                        end
                    end
                end
                2'b11: begin
                    // Out-of-range loads saturate and latch the sticky error.
                    state_d = StCount;
                    if (bus.D > MaxQ) begin
                        q_d   = MaxQ;
                        err_d = 1'b1;
                    end else begin
                        q_d = bus.D;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Q    = q_q;
    assign bus.RCO  = rco_q;
    assign bus.DONE = (state_q == StHalt);
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_contador_param.sv
module tb_contador_param;

    localparam int MA = 31;  // dut_a: defaults WIDTH=5, MAXVAL=31
    localparam int MB = 9;   // dut_b: WIDTH=4, MAXVAL=9

    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;

    // Reference state per instance
    int ma_q, mb_q;
    bit ma_rco, ma_done, ma_err, mb_rco, mb_done, mb_err;

    contador_param_if #(.WIDTH(5)) bus_a ();
    contador_param_if #(.WIDTH(4)) bus_b ();

    contador_param dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_a)
    );

    contador_param #(.WIDTH(4), .MAXVAL(9)) dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    // Behavioural rules: values live in 0..m, arithmetic modulo m+1.
    task automatic model_step(input int m, input bit clr, input bit enb, input int mode,
                              input bit os, input int d, inout int q, inout bit rco,
                              inout bit done, inout bit err);
        bit term;
        rco = 1'b0;
        if (clr) begin
            q = 0; err = 1'b0; done = 1'b0;
        end else if (enb) begin
            if ((mode == 1 || mode == 2) && !done) begin
                term = (mode == 1) ? (q == m) : (q == 0);
                rco  = term;
                if (term && os) done = 1'b1;
                else if (mode == 1) q = (q + 1) % (m + 1);
                else q = (q + m) % (m + 1);
            end else if (mode == 3) begin
                if (d > m) begin q = m; err = 1'b1; end
                else q = d;
                done = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        ma_q = 0; ma_rco = 0; ma_done = 0; ma_err = 0;
        mb_q = 0; mb_rco = 0; mb_done = 0; mb_err = 0;
    endtask

    // One clock edge; models advance on the inputs present at the edge.
    task automatic tick();
        @(posedge CLK);
        model_step(MA, bus_a.CLR, bus_a.ENB, int'(bus_a.MODE), bus_a.ONESHOT, int'(bus_a.D),
                   ma_q, ma_rco, ma_done, ma_err);
        model_step(MB, bus_b.CLR, bus_b.ENB, int'(bus_b.MODE), bus_b.ONESHOT, int'(bus_b.D),
                   mb_q, mb_rco, mb_done, mb_err);
        #1;
    endtask

    task automatic set_a(input bit clr, input bit enb, input int mode, input bit os,
                         input int d);
        bus_a.CLR = clr; bus_a.ENB = enb; bus_a.MODE = 2'(mode);
        bus_a.ONESHOT = os; bus_a.D = 5'(d);
    endtask

    task automatic set_b(input bit clr, input bit enb, input int mode, input bit os,
                         input int d);
        bus_b.CLR = clr; bus_b.ENB = enb; bus_b.MODE = 2'(mode);
        bus_b.ONESHOT = os; bus_b.D = 4'(d);
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        RESET = 1'b0;
        #2;
        tests++;
        if ({bus_a.Q, bus_a.RCO, bus_a.DONE, bus_a.ERR} !== 8'h00) begin
            fails++;
            $display("FAIL reset_a: Q/RCO/DONE/ERR=%b required 00000000",
                     {bus_a.Q, bus_a.RCO, bus_a.DONE, bus_a.ERR});
        end
        tests++;
        if ({bus_b.Q, bus_b.RCO, bus_b.DONE, bus_b.ERR} !== 7'h00) begin
            fails++;
            $display("FAIL reset_b: Q/RCO/DONE/ERR=%b required 0000000",
                     {bus_b.Q, bus_b.RCO, bus_b.DONE, bus_b.ERR});
        end
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_up_wrap();
        int e;
        pulse_reset();
        set_a(0, 1, 1, 0, 0);
        for (int k = 1; k <= 33; k++) begin
            tick();
            e = k % 32;
            tests++;
            if (bus_a.Q !== 5'(e) || bus_a.RCO !== (e == 0)) begin
                fails++;
                $display("FAIL up_wrap edge %0d: Q=%0d RCO=%b required Q=%0d RCO=%b",
                         k, bus_a.Q, bus_a.RCO, e, (e == 0));
            end
        end
    endtask

    task automatic test_down_wrap();
        int e;
        pulse_reset();
        set_b(0, 1, 2, 0, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            e = ((9 - k) % 10 + 10) % 10;
            tests++;
            if (bus_b.Q !== 4'(e) || bus_b.RCO !== (k == 0 || k == 10) || bus_b.Q > 4'd9) begin
                fails++;
                $display("FAIL down_wrap edge %0d: Q=%0d RCO=%b required Q=%0d RCO=%b",
                         k, bus_b.Q, bus_b.RCO, e, (k == 0 || k == 10));
            end
        end
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_oneshot();
        int eq[5]   = '{30, 31, 31, 31, 31};
        bit erco[5] = '{0, 0, 1, 0, 0};
        bit edn[5]  = '{0, 0, 1, 1, 1};
        set_a(0, 1, 3, 1, 29);
        tick();
        tests++;
        if (bus_a.Q !== 5'd29 || bus_a.DONE !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_load: Q=%0d DONE=%b required Q=29 DONE=0", bus_a.Q, bus_a.DONE);
        end
        set_a(0, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus_a.ONESHOT = 1'b0;  // no effect while halted
            tick();
            tests++;
            if (bus_a.Q !== 5'(eq[k]) || bus_a.RCO !== erco[k] || bus_a.DONE !== edn[k]) begin
                fails++;
                $display("FAIL oneshot edge %0d: Q=%0d RCO=%b DONE=%b required %0d %b %b",
                         k, bus_a.Q, bus_a.RCO, bus_a.DONE, eq[k], erco[k], edn[k]);
            end
        end
        set_a(0, 1, 3, 0, 5);
        tick();
        tests++;
        if (bus_a.Q !== 5'd5 || bus_a.DONE !== 1'b0 || bus_a.RCO !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_reload: Q=%0d DONE=%b RCO=%b required Q=5 DONE=0 RCO=0",
                     bus_a.Q, bus_a.DONE, bus_a.RCO);
        end
    endtask

    task automatic test_err();
        int  dv[3] = '{12, 3, 0};
        int  eq[3] = '{9, 3, 0};
        bit  ee[3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            if (k < 2) set_b(0, 1, 3, 0, dv[k]);
            else set_b(1, 0, 0, 0, 0);
            tick();
            tests++;
            if (bus_b.Q !== 4'(eq[k]) || bus_b.ERR !== ee[k]) begin
                fails++;
                $display("FAIL err step %0d: Q=%0d ERR=%b required Q=%0d ERR=%b",
                         k, bus_b.Q, bus_b.ERR, eq[k], ee[k]);
            end
        end
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_enb_clr();
        set_a(0, 1, 3, 0, 20);
        tick();
        set_a(0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (bus_a.Q !== 5'd20 || bus_a.RCO !== 1'b0) begin
                fails++;
                $display("FAIL enb_hold edge %0d: Q=%0d RCO=%b required Q=20 RCO=0",
                         k, bus_a.Q, bus_a.RCO);
            end
        end
        set_a(1, 1, 3, 0, 7);
        tick();
        tests++;
        if (bus_a.Q !== 5'd0) begin
            fails++;
            $display("FAIL clr_priority: Q=%0d required 0", bus_a.Q);
        end
    endtask

    task automatic test_load_terminal();
        set_a(0, 1, 3, 0, 31);
        set_b(0, 1, 3, 0, 0);
        tick();
        tests++;
        if (bus_a.RCO !== 1'b0 || bus_b.RCO !== 1'b0 || bus_a.Q !== 5'd31) begin
            fails++;
            $display("FAIL load_terminal: RCO_a=%b RCO_b=%b Q_a=%0d required 0 0 31",
                     bus_a.RCO, bus_b.RCO, bus_a.Q);
        end
        set_a(0, 1, 1, 0, 0);
        set_b(0, 1, 2, 0, 0);
        tick();
        tests++;
        if (bus_a.Q !== 5'd0 || bus_a.RCO !== 1'b1 || bus_b.Q !== 4'd9 || bus_b.RCO !== 1'b1) begin
            fails++;
            $display("FAIL count_after_load: Q_a=%0d RCO_a=%b Q_b=%0d RCO_b=%b required 0 1 9 1",
                     bus_a.Q, bus_a.RCO, bus_b.Q, bus_b.RCO);
        end
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_a(0, 1, 3, 0, 17);
        tick();
        RESET = 1'b0;
        #1;
        tests++;
        if (bus_a.Q !== 5'd0 || bus_a.DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: Q=%0d DONE=%b required Q=0 DONE=0", bus_a.Q, bus_a.DONE);
        end
        RESET = 1'b1;
        model_reset();
        set_a(0, 1, 1, 0, 0);
        tick();
        tests++;
        if (bus_a.Q !== 5'd1 || bus_a.RCO !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: Q=%0d RCO=%b required Q=1 RCO=0", bus_a.Q, bus_a.RCO);
        end
        // Halt, then reset right after the terminal edge: no RCO after release.
        set_a(0, 1, 3, 1, 31);
        tick();
        set_a(0, 1, 1, 1, 0);
        tick();
        pulse_reset();
        set_a(0, 1, 0, 0, 0);
        tick();
        tests++;
        if (bus_a.RCO !== 1'b0 || bus_a.DONE !== 1'b0 || bus_a.Q !== 5'd0) begin
            fails++;
            $display("FAIL reset_halt: Q=%0d RCO=%b DONE=%b required 0 0 0",
                     bus_a.Q, bus_a.RCO, bus_a.DONE);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_a(($urandom_range(31) == 0), ($urandom_range(7) != 0), int'($urandom_range(3)),
                  1'($urandom_range(1)), int'($urandom_range(31)));
            set_b(($urandom_range(31) == 0), ($urandom_range(7) != 0), int'($urandom_range(3)),
                  1'($urandom_range(1)), int'($urandom_range(15)));
            if ($urandom_range(99) == 0) pulse_reset();
            tick();
            tests++;
            if (bus_a.Q !== 5'(ma_q) || bus_a.RCO !== ma_rco || bus_a.DONE !== ma_done ||
                bus_a.ERR !== ma_err) begin
                fails++;
                $display("FAIL random_a cycle %0d: Q=%0d RCO=%b DONE=%b ERR=%b required %0d %b %b %b",
                         n, bus_a.Q, bus_a.RCO, bus_a.DONE, bus_a.ERR,
                         ma_q, ma_rco, ma_done, ma_err);
            end
            tests++;
            if (bus_b.Q !== 4'(mb_q) || bus_b.RCO !== mb_rco || bus_b.DONE !== mb_done ||
                bus_b.ERR !== mb_err) begin
                fails++;
                $display("FAIL random_b cycle %0d: Q=%0d RCO=%b DONE=%b ERR=%b required %0d %b %b %b",
                         n, bus_b.Q, bus_b.RCO, bus_b.DONE, bus_b.ERR,
                         mb_q, mb_rco, mb_done, mb_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_oneshot();
        test_err();
        test_enb_clr();
        test_load_terminal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
